coherent_mem_ctrl: RTL and testbench

Synthesizable, parametrised directory memory controller at the ring head (node 0). It accepts line requests and write data captured from the ring, tracks a per-line coherence directory (CLEAN/WAITING/MODIFIED), and streams read lines onto the pipelined RDreturn bus. Refused or directory-only requests go out through a resend port that feeds the ring's resend queue. Compared with the simulation-only controller, it adds parametrised line size, directory init sweep, write-data and resend backpressure, address range checking and statistics.

---
 rtl/coherent_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_coherent_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherent_mem_ctrl.sv
// Ring-head directory memory controller: serves line reads/writes, tracks CLEAN/WAITING/MODIFIED
// per line, streams read lines on the return bus and refers refused or directory-only reads to the resend queue.
module coherent_mem_ctrl #(
   parameter int    MBITS     = 20,
   parameter int    LINE_LOG  = 3,
   parameter int    MOD_LINES = 128,
   parameter int    STAT_W    = 16,
   parameter string INIT_FILE = ""
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ma_valid,
   output logic              ma_ready,
   input  logic [31:0]       ma_addr,
   input  logic [3:0]        ma_src,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [31:0]       md_data,
   output logic [31:0]       rd_data,
   output logic [3:0]        rd_dest,
   output logic              rq_valid,
   input  logic              rq_ready,
   output logic [31:0]       rq_data,
   output logic [3:0]        rq_type,
   output logic [3:0]        rq_dest,
   output logic              busy_init,
   output logic              err_addr,
   output logic [STAT_W-1:0] read_cnt,
   output logic [STAT_W-1:0] write_cnt,
   output logic [STAT_W-1:0] nack_cnt
);
   localparam int DIR_AW     = MBITS - LINE_LOG;
   localparam int DIR_LINES  = 1 << DIR_AW;
   localparam int LINE_WORDS = 1 << LINE_LOG;
   localparam logic [LINE_LOG-1:0] LAST_WORD = LINE_LOG'(LINE_WORDS - 1);
   localparam logic [DIR_AW-1:0]   LAST_LINE = DIR_AW'(DIR_LINES - 1);

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND_RD, ST_WR_DATA} state_t;
   localparam logic [1:0] DIR_CLEAN    = 2'd0;
   localparam logic [1:0] DIR_WAITING  = 2'd1;
   localparam logic [1:0] DIR_MODIFIED = 2'd2;

   logic [31:0] mem     [0:(1<<MBITS)-1];
   logic [1:0]  dir_mem [0:DIR_LINES-1];

   state_t              state_reg;
   logic [DIR_AW-1:0]   init_idx_reg;
   logic [DIR_AW-1:0]   line_reg;
   logic [LINE_LOG-1:0] word_reg;
   logic [3:0]          src_reg;

   logic [DIR_AW-1:0]   req_line;
   logic                req_oor;
   logic [1:0]          cur_dir;
   logic                rd_ok;
   logic                in_idle;
   logic                dir_we;
   logic [1:0]          dir_wdata;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Request decode and directory lookup happen in the same IDLE cycle as the pop decision.
   always_comb begin
      req_line  = ma_addr[DIR_AW-1:0];
      req_oor   = (ma_addr[27:0] >> DIR_AW) != 28'd0;
      cur_dir   = dir_mem[req_line];
      rd_ok     = (cur_dir == DIR_CLEAN) || ((cur_dir == DIR_WAITING) && ma_addr[31]);
      in_idle   = (state_reg == ST_IDLE);
      rq_valid  = in_idle && ma_valid && !req_oor && ma_addr[28] && (!rd_ok || ma_addr[30]);
      ma_ready  = in_idle && ma_valid &&
                  (req_oor || !ma_addr[28] || (rd_ok && !ma_addr[30]) || rq_ready);
      rq_type   = 4'd0;
      rq_data   = 32'd0;
      rq_dest   = 4'd0;
      if (rq_valid) begin
         rq_dest = ma_src;
         if (rd_ok) begin
            rq_type = 4'd6;
            rq_data = {4'h0, ma_addr[27:0]};
         end else begin
            rq_type = 4'd2;
            rq_data = {1'b1, ma_addr[30:0]};
         end
      end
      dir_we    = ma_ready && !req_oor && (!ma_addr[28] || rd_ok);
      dir_wdata = ma_addr[28] ? (ma_addr[29] ? DIR_MODIFIED : DIR_CLEAN)
                              : (ma_addr[29] ? DIR_WAITING  : DIR_CLEAN);
      busy_init = (state_reg == ST_INIT);
      md_ready  = (state_reg == ST_WR_DATA);
   end

   always_ff @(posedge clock) begin
      if (state_reg == ST_INIT)
         dir_mem[init_idx_reg] <= (int'(init_idx_reg) < MOD_LINES) ? DIR_MODIFIED : DIR_CLEAN;
      else if (dir_we)
         dir_mem[req_line] <= dir_wdata;
   end

   always_ff @(posedge clock) begin
      if (state_reg == ST_WR_DATA && md_valid)
         mem[{line_reg, word_reg}] <= md_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_INIT;
         init_idx_reg <= '0;
         line_reg     <= '0;
         word_reg     <= '0;
         src_reg      <= 4'd0;
         rd_data      <= 32'd0;
         rd_dest      <= 4'd0;
         err_addr     <= 1'b0;
         read_cnt     <= '0;
         write_cnt    <= '0;
         nack_cnt     <= '0;
      end else begin
         rd_data <= 32'd0;
         rd_dest <= 4'd0;
         case (state_reg)
            ST_INIT: begin
               init_idx_reg <= init_idx_reg + 1'b1;
               if (init_idx_reg == LAST_LINE)
                  state_reg <= ST_IDLE;
            end
            ST_IDLE: begin
               if (ma_ready) begin
                  word_reg <= '0;
                  line_reg <= req_line;
                  src_reg  <= ma_src;
                  if (req_oor) begin
                     err_addr <= 1'b1;
                  end else if (ma_addr[28]) begin
                     if (!rd_ok) begin
                        nack_cnt <= sat_inc(nack_cnt);
                     end else begin
                        read_cnt <= sat_inc(read_cnt);
                        if (!ma_addr[30])
                           state_reg <= ST_SEND_RD;
                     end
                  end else begin
                     write_cnt <= sat_inc(write_cnt);
                     state_reg <= ST_WR_DATA;
                  end
               end
            end
            ST_SEND_RD: begin
               rd_data  <= mem[{line_reg, word_reg}];
               rd_dest  <= src_reg;
               word_reg <= word_reg + 1'b1;
               if (word_reg == LAST_WORD)
                  state_reg <= ST_IDLE;
            end
            ST_WR_DATA: begin
               if (md_valid) begin
                  word_reg <= word_reg + 1'b1;
                  if (word_reg == LAST_WORD)
                     state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_coherent_mem_ctrl.sv
// Scoreboard bench for coherent_mem_ctrl: driver predicts responses from a line-level directory/memory model,
// a negedge monitor pops and compares every return word and resend handshake.
module tb_coherent_mem_ctrl;
   localparam int MBITS = 10, LINE_LOG = 3, MOD_LINES = 4, STAT_W = 5;
   localparam int NLINES = 128, LW = 8, SAT_MAX = 31;
   localparam int D_CLEAN = 0, D_WAIT = 1, D_MOD = 2;

   logic clock, reset, ma_valid, ma_ready, md_valid, md_ready;
   logic rq_valid, rq_ready, busy_init, err_addr;
   logic [31:0] ma_addr, md_data, rd_data, rq_data;
   logic [3:0]  ma_src, rd_dest, rq_type, rq_dest;
   logic [STAT_W-1:0] read_cnt, write_cnt, nack_cnt;

   coherent_mem_ctrl #(.MBITS(MBITS), .LINE_LOG(LINE_LOG), .MOD_LINES(MOD_LINES),
                       .STAT_W(STAT_W), .INIT_FILE("")) dut (
      .clock(clock), .reset(reset),
      .ma_valid(ma_valid), .ma_ready(ma_ready), .ma_addr(ma_addr), .ma_src(ma_src),
      .md_valid(md_valid), .md_ready(md_ready), .md_data(md_data),
      .rd_data(rd_data), .rd_dest(rd_dest),
      .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_data(rq_data), .rq_type(rq_type), .rq_dest(rq_dest),
      .busy_init(busy_init), .err_addr(err_addr),
      .read_cnt(read_cnt), .write_cnt(write_cnt), .nack_cnt(nack_cnt));

   typedef struct { int cyc; logic [3:0] dest; logic [31:0] data; bit known; } rd_exp_t;
   typedef struct { logic [3:0] rtype; logic [31:0] data; logic [3:0] dest; } rq_exp_t;
   rd_exp_t rd_q[$];
   rq_exp_t rq_q[$];

   int          dir_m [NLINES];
   logic [31:0] mem_m [1024];
   bit          known_m [1024];
   int          read_m, write_m, nack_m;
   bit          err_m;
   logic [31:0] wr_words [LW];
   int          checks, passes, cyc;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   function automatic void bound_expired(input string name);
      checks++;
      $display("FAIL %s: wait bound expired, got no handshake, required one (cycle %0d)", name, cyc);
   endfunction

   function automatic int sat_inc(input int v);
      return (v < SAT_MAX) ? v + 1 : SAT_MAX;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NLINES; i++) dir_m[i] = (i < MOD_LINES) ? D_MOD : D_CLEAN;
      read_m = 0; write_m = 0; nack_m = 0; err_m = 1'b0;
   endfunction

   // Monitor: every non-idle return word and every resend handshake must match the scoreboard head.
   initial begin
      rd_exp_t e;
      rq_exp_t r;
      forever begin
         @(negedge clock);
         if (rd_dest != 4'd0) begin
            if (rd_q.size() == 0) check("rd_unexpected_dest", 32'(rd_dest), 32'd0);
            else begin
               e = rd_q.pop_front();
               check("rd_dest", 32'(rd_dest), 32'(e.dest));
               check("rd_cycle", 32'(cyc), 32'(e.cyc));
               if (e.known) check("rd_data", rd_data, e.data);
            end
         end else if (reset) check("rd_idle_data", rd_data, 32'd0);
         if (rq_valid && rq_ready) begin
            if (rq_q.size() == 0) check("rq_unexpected", 32'(rq_valid), 32'd0);
            else begin
               r = rq_q.pop_front();
               check("rq_type", 32'(rq_type), 32'(r.rtype));
               check("rq_data", rq_data, r.data);
               check("rq_dest", 32'(rq_dest), 32'(r.dest));
            end
         end
      end
   end

   task automatic count_busy();
      int cnt;
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (busy_init) cnt++;
         else break;
      end
      check("busy_init_cycles", 32'(cnt), 32'd128);
   endtask

   task automatic do_req(input logic [31:0] addr, input logic [3:0] src, input int gap_mode,
                         input int hold_off, output int held);
      bit oor, rd, excl, donly, retry, ok, need_rq;
      int ln, waited, k, t;
      rq_exp_t rqe;
      rd_exp_t rde;
      oor   = (addr[27:0] >> 7) != 28'd0;
      ln    = int'(addr[6:0]);
      retry = addr[31]; donly = addr[30]; excl = addr[29]; rd = addr[28];
      ok    = (dir_m[ln] == D_CLEAN) || (dir_m[ln] == D_WAIT && retry);
      need_rq = !oor && rd && (!ok || donly);
      held = 0; waited = 0;
      rqe.rtype = ok ? 4'd6 : 4'd2;
      rqe.data  = ok ? {4'h0, addr[27:0]} : {1'b1, addr[30:0]};
      rqe.dest  = src;
      if (need_rq) rq_q.push_back(rqe);
      @(posedge clock); #1;
      ma_valid = 1'b1; ma_addr = addr; ma_src = src;
      forever begin
         rq_ready = (waited >= hold_off);
         #1;
         if (rq_valid && !rq_ready) begin
            held++;
            check("rq_hold_expected", 32'(need_rq), 32'd1);
            check("rq_hold_ma_ready", 32'(ma_ready), 32'd0);
            check("rq_hold_data", rq_data, rqe.data);
         end
         if (ma_ready) break;
         if (waited >= 60) begin
            bound_expired("pop_timeout");
            ma_valid = 1'b0; rq_ready = 1'b0;
            return;
         end
         @(posedge clock); #1;
         waited++;
      end
      @(posedge clock); #1;
      k = cyc; ma_valid = 1'b0; rq_ready = 1'b0;
      if (oor) err_m = 1'b1;
      else if (rd) begin
         if (!ok) nack_m = sat_inc(nack_m);
         else begin
            read_m = sat_inc(read_m);
            dir_m[ln] = excl ? D_MOD : D_CLEAN;
            if (!donly)
               for (int i = 0; i < LW; i++) begin
                  rde.cyc = k + 1 + i; rde.dest = src;
                  rde.data = mem_m[ln*LW+i]; rde.known = known_m[ln*LW+i];
                  rd_q.push_back(rde);
               end
         end
      end else begin
         write_m = sat_inc(write_m);
         dir_m[ln] = excl ? D_WAIT : D_CLEAN;
      end
      check("err_addr", 32'(err_addr), 32'(err_m));
      check("read_cnt", 32'(read_cnt), 32'(read_m));
      check("write_cnt", 32'(write_cnt), 32'(write_m));
      check("nack_cnt", 32'(nack_cnt), 32'(nack_m));
      if (!oor && !rd) begin
         for (int i = 0; i < LW; i++) begin
            t = 0;
            forever begin
               md_valid = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (t % 2 == 1) : 1'($urandom_range(0, 1));
               md_data  = wr_words[i];
               #1;
               if (md_valid && md_ready) break;
               if (t >= 40) begin
                  bound_expired("md_timeout");
                  md_valid = 1'b0;
                  return;
               end
               @(posedge clock); #1;
               t++;
            end
            @(posedge clock); #1;
            md_valid = 1'b0;
            mem_m[ln*LW+i] = wr_words[i];
            known_m[ln*LW+i] = 1'b1;
         end
         #1 check("wr_done_idle", 32'(md_ready), 32'd0);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
   endtask

   initial begin
      int held, k;
      logic [31:0] a;
      checks = 0; passes = 0; cyc = 0;
      ma_valid = 1'b1; ma_addr = 32'h1000_0003; ma_src = 4'd1;
      md_valid = 1'b0; md_data = 32'd0; rq_ready = 1'b1;
      for (int i = 0; i < 1024; i++) begin mem_m[i] = 32'd0; known_m[i] = 1'b0; end
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ma_ready", 32'(ma_ready), 32'd0);
      check("rst_md_ready", 32'(md_ready), 32'd0);
      check("rst_rq_valid", 32'(rq_valid), 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_rd_dest", 32'(rd_dest), 32'd0);
      check("rst_err_addr", 32'(err_addr), 32'd0);
      check("rst_counters", 32'({read_cnt, write_cnt, nack_cnt}), 32'd0);
      check("rst_busy_init", 32'(busy_init), 32'd1);
      ma_valid = 1'b0; rq_ready = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      count_busy();

      do_req(32'h1000_0003, 4'd1, 0, 0, held);       // MODIFIED from the sweep: nack
      do_req(32'h1000_0004, 4'd1, 0, 0, held);       // CLEAN: data
      for (int i = 0; i < LW; i++) wr_words[i] = 32'h100 + i;
      do_req(32'h0000_0005, 4'd1, 0, 0, held);
      do_req(32'h1000_0005, 4'd3, 0, 0, held);

      do_req(32'h3000_0006, 4'd2, 0, 0, held);
      do_req(32'h1000_0006, 4'd4, 0, 2, held);
      for (int i = 0; i < LW; i++) wr_words[i] = $urandom;
      do_req(32'h2000_0006, 4'd2, 0, 0, held);
      do_req(32'h9000_0006, 4'd4, 0, 0, held);
      do_req(32'h1000_0006, 4'd5, 0, 0, held);

      wait_cycles(12);
      do_req(32'h5000_0005, 4'd7, 0, 5, held);
      check("dironly_hold_cycles", 32'(held), 32'd5);

      for (int i = 0; i < LW; i++) wr_words[i] = 32'hA00 + i;
      do_req(32'h0000_0009, 4'd1, 1, 0, held);
      do_req(32'h1000_0009, 4'd6, 0, 0, held);

      do_req(32'h1800_0000, 4'd1, 0, 0, held);
      do_req(32'h1000_0000, 4'd1, 0, 0, held);       // line 0 must still be MODIFIED

      for (int n = 0; n < 150; n++) begin
         a = 32'($urandom_range(0, 11));
         a[28] = ($urandom_range(0, 2) != 0);
         a[29] = 1'($urandom_range(0, 1));
         a[30] = ($urandom_range(0, 3) == 0);
         a[31] = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) a[27:7] = 21'($urandom_range(1, 2097151));
         for (int i = 0; i < LW; i++) wr_words[i] = $urandom;
         do_req(a, 4'($urandom_range(1, 15)), 2, int'($urandom_range(0, 3)), held);
      end

      wait_cycles(12);
      for (int i = 0; i < LW; i++) wr_words[i] = 32'h2000 + i;
      do_req(32'h0000_0014, 4'd1, 2, 0, held);
      do_req(32'h1000_0014, 4'd3, 0, 0, held);
      k = cyc;
      while (cyc < k + 3) begin @(posedge clock); #1; end
      @(negedge clock); #1;
      reset = 1'b0;
      #1;
      check("midread_rd_dest", 32'(rd_dest), 32'd0);
      check("midread_rd_data", rd_data, 32'd0);
      check("midread_busy_init", 32'(busy_init), 32'd1);
      rd_q.delete();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("midread_counters", 32'({read_cnt, write_cnt, nack_cnt}), 32'd0);
      reset = 1'b1;
      count_busy();
      do_req(32'h1000_0014, 4'd9, 0, 0, held);
      do_req(32'h1000_0002, 4'd9, 0, 0, held);

      for (int i = 0; i < 50 && rd_q.size() != 0; i++) @(posedge clock);
      @(negedge clock); #1;
      check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
      check("rq_queue_drained", 32'(rq_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
